// File: rtl/e18_resp_monitor.sv
// e18_resp_monitor: passive checker for the e18 controller 12-bit response bus.
// Classifies each valid response word, enforces the mandatory one-step
// successions, captures the first violation, and counts entries into s14.
module e18_resp_monitor #(
  parameter int CNT_W       = 16,
  parameter int TRIG_W      = 8,
  parameter int TRIG_THRESH = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              y_valid,
  input  logic [11:0]       y_word,
  output logic              err,
  output logic [2:0]        err_code,
  output logic [CNT_W-1:0]  err_index,
  output logic [CNT_W-1:0]  sample_cnt,
  output logic [TRIG_W-1:0] trig_cnt,
  output logic              trig_alarm
);

  // Response words, bit0 = y1 ... bit11 = y12
  localparam logic [11:0] C_IDLE = 12'h000;
  localparam logic [11:0] C_S2   = 12'h400;
  localparam logic [11:0] C_S3   = 12'h002;
  localparam logic [11:0] C_S4   = 12'h1C0;
  localparam logic [11:0] C_S5   = 12'h001;
  localparam logic [11:0] C_S6   = 12'h004;
  localparam logic [11:0] C_S7   = 12'h020;
  localparam logic [11:0] C_S8   = 12'h980;
  localparam logic [11:0] C_S10  = 12'h008;
  localparam logic [11:0] C_S11  = 12'h030;
  localparam logic [11:0] C_S13  = 12'h880;
  localparam logic [11:0] C_S14  = 12'h0C0;
  localparam logic [11:0] C_S15  = 12'h300;

  typedef enum logic [2:0] {
    EXP_ANY,
    EXP_S14,
    EXP_AFT14,
    EXP_AFT6,
    EXP_S13
  } exp_t;

  exp_t              r_exp;
  exp_t              w_exp_next;
  logic              w_legal;
  logic [2:0]        w_code;
  logic [TRIG_W-1:0] w_trig_next;

  logic              r_err;
  logic [2:0]        r_err_code;
  logic [CNT_W-1:0]  r_err_index;
  logic [CNT_W-1:0]  r_sample_cnt;
  logic [TRIG_W-1:0] r_trig_cnt;
  logic              r_trig_alarm;

  // Word legality: exactly one of the thirteen destination codes
  always_comb begin
    w_legal = 1'b0;
    case (y_word)
      C_IDLE, C_S2, C_S3, C_S4, C_S5, C_S6, C_S7,
      C_S8, C_S10, C_S11, C_S13, C_S14, C_S15: w_legal = 1'b1;
      default: w_legal = 1'b0;
    endcase
  end

  // Violation code and next expectation for the current valid sample
  always_comb begin
    w_exp_next = r_exp;
    w_code     = '0;
    if (y_valid) begin
      case (r_exp)
        EXP_S14:   if (y_word != C_S14) w_code = 3'd1;
        EXP_AFT14: if (y_word != C_S10 && y_word != C_S15) w_code = 3'd2;
        EXP_AFT6:  if (y_word != C_IDLE && y_word != C_S2 && y_word != C_S13) w_code = 3'd3;
        EXP_S13:   if (y_word != C_S13) w_code = 3'd4;
        default:   w_code = '0;
      endcase
      // Illegal word overrides any succession code
      if (!w_legal) w_code = 3'd5;
      // Next expectation follows the current word even after a violation
      case (y_word)
        C_S7:    w_exp_next = EXP_S14;
        C_S14:   w_exp_next = EXP_AFT14;
        C_S6:    w_exp_next = EXP_AFT6;
        C_S2:    w_exp_next = (r_exp == EXP_AFT6) ? EXP_S13 : EXP_ANY;
        default: w_exp_next = EXP_ANY;
      endcase
    end
  end

  // Saturating s14-entry count after this sample
  always_comb begin
    w_trig_next = r_trig_cnt;
    if (y_valid && y_word == C_S14 && r_trig_cnt != '1) begin
      w_trig_next = r_trig_cnt + TRIG_W'(1);
    end
  end

  // Expectation state register
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_exp <= EXP_ANY;
    end else begin
      r_exp <= w_exp_next;
    end
  end

  // Counters, first-error capture and alarm
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_err        <= 1'b0;
      r_err_code   <= '0;
      r_err_index  <= '0;
      r_sample_cnt <= '0;
      r_trig_cnt   <= '0;
      r_trig_alarm <= 1'b0;
    end else if (y_valid) begin
      if (w_code != '0 && !r_err) begin
        r_err       <= 1'b1;
        r_err_code  <= w_code;
        r_err_index <= r_sample_cnt;
      end
      r_sample_cnt <= r_sample_cnt + CNT_W'(1);
      r_trig_cnt   <= w_trig_next;
      // Count never decreases outside rst/clr, so this stays high once set
      r_trig_alarm <= (w_trig_next >= TRIG_W'(TRIG_THRESH));
    end
  end

  assign err        = r_err;
  assign err_code   = r_err_code;
  assign err_index  = r_err_index;
  assign sample_cnt = r_sample_cnt;
  assign trig_cnt   = r_trig_cnt;
  assign trig_alarm = r_trig_alarm;

endmodule

// File: tb/tb_e18_resp_monitor.sv
// Bench for e18_resp_monitor: reference model driven by allowed-word sets,
// per-cycle comparison, directed scenarios with literal expectations, and
// weighted random stimulus.
module tb_e18_resp_monitor;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clr = 1'b0;
  logic        y_valid = 1'b0;
  logic [11:0] y_word = '0;
  logic        err;
  logic [2:0]  err_code;
  logic [15:0] err_index;
  logic [15:0] sample_cnt;
  logic [7:0]  trig_cnt;
  logic        trig_alarm;

  int checks = 0;
  int failures = 0;

  e18_resp_monitor #(.CNT_W(16), .TRIG_W(8), .TRIG_THRESH(5)) dut (
    .clk(clk), .rst(rst), .clr(clr), .y_valid(y_valid), .y_word(y_word),
    .err(err), .err_code(err_code), .err_index(err_index),
    .sample_cnt(sample_cnt), .trig_cnt(trig_cnt), .trig_alarm(trig_alarm)
  );

  always #5 clk = ~clk;

  logic [11:0] legal_tab [13] = '{12'h000, 12'h400, 12'h002, 12'h1C0, 12'h001,
                                  12'h004, 12'h020, 12'h980, 12'h008, 12'h030,
                                  12'h880, 12'h0C0, 12'h300};

  // Model state: allowed next words (m_n == 0 means unconstrained)
  bit          m_on = 0;
  int          m_n = 0;
  logic [11:0] m_set [3];
  int          m_vcode = 0;
  int          m_err = 0, m_code = 0, m_idx = 0, m_cnt = 0, m_trig = 0, m_alarm = 0;

  function automatic bit is_legal(logic [11:0] w);
    for (int i = 0; i < 13; i++) if (legal_tab[i] == w) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit in_set(logic [11:0] w);
    for (int i = 0; i < m_n; i++) if (m_set[i] == w) return 1'b1;
    return 1'b0;
  endfunction

  task automatic set_exp(int n, logic [11:0] a, logic [11:0] b, logic [11:0] c, int code);
    m_n = n; m_set[0] = a; m_set[1] = b; m_set[2] = c; m_vcode = code;
  endtask

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model update on each rising edge
  always @(posedge clk) begin
    int code;
    bit was_aft6;
    if (rst || clr) begin
      if (rst) m_on = 1;
      m_err = 0; m_code = 0; m_idx = 0; m_cnt = 0; m_trig = 0; m_alarm = 0;
      set_exp(0, 0, 0, 0, 0);
    end else if (y_valid) begin
      code = 0;
      if (!is_legal(y_word)) code = 5;
      else if (m_n > 0 && !in_set(y_word)) code = m_vcode;
      if (code != 0 && m_err == 0) begin
        m_err = 1; m_code = code; m_idx = m_cnt;
      end
      m_cnt = (m_cnt + 1) % 65536;
      if (y_word == 12'h0C0 && m_trig < 255) m_trig++;
      m_alarm = (m_trig >= 5) ? 1 : 0;
      was_aft6 = (m_n > 0 && m_vcode == 3);
      if (y_word == 12'h020)                 set_exp(1, 12'h0C0, 0, 0, 1);
      else if (y_word == 12'h0C0)            set_exp(2, 12'h008, 12'h300, 0, 2);
      else if (y_word == 12'h004)            set_exp(3, 12'h000, 12'h400, 12'h880, 3);
      else if (y_word == 12'h400 && was_aft6) set_exp(1, 12'h880, 0, 0, 4);
      else                                   set_exp(0, 0, 0, 0, 0);
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (m_on) begin
      chk("err", int'(err), m_err);
      chk("err_code", int'(err_code), m_code);
      chk("err_index", int'(err_index), m_idx);
      chk("sample_cnt", int'(sample_cnt), m_cnt);
      chk("trig_cnt", int'(trig_cnt), m_trig);
      chk("trig_alarm", int'(trig_alarm), m_alarm);
    end
  end

  task automatic drive(logic r, logic c, logic v, logic [11:0] w);
    @(negedge clk);
    rst = r; clr = c; y_valid = v; y_word = w;
  endtask

  task automatic vw(logic [11:0] w);
    drive(1'b0, 1'b0, 1'b1, w);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 12'h000);
  endtask

  task automatic do_rst();
    drive(1'b1, 1'b0, 1'b0, 12'h000);
  endtask

  // Waits for the edge that captures the last driven inputs
  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [11:0] w;
    int r;

    do_rst();
    settle();
    chk("rst_err", int'(err), 0);
    chk("rst_sample_cnt", int'(sample_cnt), 0);
    chk("rst_trig_alarm", int'(trig_alarm), 0);

    // Legal s7 -> s14 -> s10 chain
    vw(12'h020); vw(12'h0C0); vw(12'h008); settle();
    chk("t1_err", int'(err), 0);
    chk("t1_sample_cnt", int'(sample_cnt), 3);
    chk("t1_trig_cnt", int'(trig_cnt), 1);
    chk("t1_alarm", int'(trig_alarm), 0);

    // Missing s14 after s7, later violations ignored
    do_rst(); vw(12'h020); vw(12'h008); settle();
    chk("t2_err", int'(err), 1);
    chk("t2_code", int'(err_code), 1);
    chk("t2_index", int'(err_index), 1);
    vw(12'h020); vw(12'h0C0); vw(12'h001); settle();
    chk("t2_code_hold", int'(err_code), 1);
    chk("t2_index_hold", int'(err_index), 1);

    // s6 -> s2 must be followed by s13
    do_rst(); vw(12'h004); vw(12'h400); vw(12'h001); settle();
    chk("t3_code", int'(err_code), 4);
    chk("t3_index", int'(err_index), 2);
    do_rst(); vw(12'h004); vw(12'h400); vw(12'h880); settle();
    chk("t3_ok_err", int'(err), 0);

    // Illegal first word, then s14 under no constraint
    do_rst(); vw(12'h003); settle();
    chk("t4_code", int'(err_code), 5);
    chk("t4_index", int'(err_index), 0);
    vw(12'h0C0); settle();
    chk("t4_code_hold", int'(err_code), 5);
    chk("t4_cnt", int'(sample_cnt), 2);

    // Five s7/s14/s15 triples with gaps
    do_rst();
    for (int t = 0; t < 5; t++) begin
      vw(12'h020); idle(); vw(12'h0C0); settle();
      chk("t5_alarm_edge", int'(trig_alarm), (t == 4) ? 1 : 0);
      idle(); vw(12'h300); idle();
    end
    settle();
    chk("t5_trig", int'(trig_cnt), 5);
    chk("t5_err", int'(err), 0);
    chk("t5_cnt", int'(sample_cnt), 15);

    // clr with a simultaneous valid word is discarded
    vw(12'h003); settle();
    chk("t6_err_pre", int'(err), 1);
    drive(1'b0, 1'b1, 1'b1, 12'h0C0); settle();
    chk("t6_err", int'(err), 0);
    chk("t6_trig", int'(trig_cnt), 0);
    chk("t6_cnt", int'(sample_cnt), 0);
    chk("t6_alarm", int'(trig_alarm), 0);
    vw(12'h020); do_rst(); vw(12'h008); settle();
    chk("t6_resync_err", int'(err), 0);

    // Saturation of the s14 counter
    do_rst();
    for (int i = 0; i < 260; i++) vw(12'h0C0);
    settle();
    chk("sat_trig", int'(trig_cnt), 255);
    chk("sat_alarm", int'(trig_alarm), 1);
    chk("sat_cnt", int'(sample_cnt), 260);

    // Weighted random traffic
    do_rst();
    for (int i = 0; i < 4000; i++) begin
      r = int'($urandom_range(0, 999));
      if (r < 5) begin
        do_rst();
      end else if (r < 35) begin
        drive(1'b0, 1'b1, $urandom_range(0, 1) == 1, legal_tab[$urandom_range(0, 12)]);
      end else if (r < 130) begin
        drive(1'b0, 1'b0, 1'b0, 12'($urandom));
      end else begin
        r = int'($urandom_range(0, 99));
        if (r < 45 && m_n > 0) w = m_set[$urandom_range(0, m_n - 1)];
        else if (r < 90) w = legal_tab[$urandom_range(0, 12)];
        else w = 12'($urandom);
        vw(w);
      end
    end
    idle();
    settle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
